// File: rtl/bsg_encode_multi_hot_serializer.sv
// Multi-hot vector serializer: accepts a vector via valid/ready and emits the
// index of every set bit, one per beat, with ordinal/count/last/empty side info.
module bsg_encode_multi_hot_serializer #(
   parameter int unsigned  width_p        = 8,
   parameter bit           lo_to_hi_p     = 1'b1,
   localparam int unsigned addr_width_lp  = (width_p > 1) ? $clog2(width_p) : 1,
   localparam int unsigned count_width_lp = $clog2(width_p + 1)
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      v_i,
   input  logic [width_p-1:0]        i,
   output logic                      ready_o,
   output logic                      v_o,
   output logic [addr_width_lp-1:0]  addr_o,
   output logic [addr_width_lp-1:0]  index_o,
   output logic [count_width_lp-1:0] count_o,
   output logic                      last_o,
   output logic                      empty_o,
   input  logic                      yumi_i
);

   localparam logic [0:0]         ST_IDLE = 1'b0;
   localparam logic [0:0]         ST_BUSY = 1'b1;
   localparam logic [width_p-1:0] ONE_W   = width_p'(1);
   localparam int                 W_INT   = int'(width_p);

   logic [0:0]                r_state,   w_state_nxt;
   logic [width_p-1:0]        r_pending, w_pending_nxt;
   logic [addr_width_lp-1:0]  r_index,   w_index_nxt;
   logic [count_width_lp-1:0] r_count,   w_count_nxt;
   logic                      r_empty,   w_empty_nxt;

   logic [addr_width_lp-1:0]  w_sel;
   logic [count_width_lp-1:0] w_popcnt;
   logic                      w_multi;
   logic                      w_busy;
   logic                      w_last;

   // Priority pick of the next set bit; the last match in loop order wins.
   always_comb begin
      w_sel = '0;
      if (lo_to_hi_p) begin
         for (int k = W_INT - 1; k >= 0; k--) begin
            if (r_pending[k]) w_sel = addr_width_lp'(k);
         end
      end else begin
         for (int k = 0; k < W_INT; k++) begin
            if (r_pending[k]) w_sel = addr_width_lp'(k);
         end
      end
   end

   always_comb begin
      w_popcnt = '0;
      for (int k = 0; k < W_INT; k++) begin
         w_popcnt = w_popcnt + count_width_lp'(i[k]);
      end
   end

   // More than one bit still pending iff clearing the lowest one leaves something.
   assign w_multi = |(r_pending & (r_pending - ONE_W));
   assign w_busy  = (r_state == ST_BUSY);
   assign w_last  = r_empty | ~w_multi;

   assign ready_o = ~w_busy;
   assign v_o     = w_busy;
   assign addr_o  = (w_busy && !r_empty) ? w_sel   : '0;
   assign index_o = (w_busy && !r_empty) ? r_index : '0;
   assign count_o = w_busy ? r_count : '0;
   assign last_o  = w_busy & w_last;
   assign empty_o = w_busy & r_empty;

   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_index_nxt   = r_index;
      w_count_nxt   = r_count;
      w_empty_nxt   = r_empty;
      case (r_state)
         ST_IDLE: begin
            if (v_i) begin
               w_pending_nxt = i;
               w_count_nxt   = w_popcnt;
               w_index_nxt   = '0;
               w_empty_nxt   = ~|i;
               w_state_nxt   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (yumi_i) begin
               w_pending_nxt = r_pending & ~(ONE_W << w_sel);
               // Index saturates on the final beat so it never reaches width_p.
               if (w_last) w_state_nxt = ST_IDLE;
               else        w_index_nxt = r_index + addr_width_lp'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state   <= ST_IDLE;
         r_pending <= '0;
         r_index   <= '0;
         r_count   <= '0;
         r_empty   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         r_index   <= w_index_nxt;
         r_count   <= w_count_nxt;
         r_empty   <= w_empty_nxt;
      end
   end

   // Protocol checks on the consumer and producer sides.
   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!(yumi_i && !w_busy))
            else $error("bsg_encode_multi_hot_serializer: yumi_i asserted with no valid beat");
         assert (!(v_i && !w_busy && $isunknown(i)))
            else $error("bsg_encode_multi_hot_serializer: unknown bits on i at accept");
      end
   end

endmodule

// File: tb/tb_bsg_encode_multi_hot_serializer.sv
// Bench for bsg_encode_multi_hot_serializer: two 8-bit instances (both scan
// orders) driven in lockstep plus a width-1 instance, checked against a bit-list model.
module tb_bsg_encode_multi_hot_serializer;

   logic       clk;
   logic       rst_n;
   logic       v_in;
   logic [7:0] vec_in;
   logic       yumi;

   logic       a_ready, a_v, a_last, a_empty;
   logic [2:0] a_addr, a_index;
   logic [3:0] a_count;
   logic       b_ready, b_v, b_last, b_empty;
   logic [2:0] b_addr, b_index;
   logic [3:0] b_count;

   logic       w1_v_in, w1_yumi;
   logic [0:0] w1_vec;
   logic       w1_ready, w1_v, w1_last, w1_empty;
   logic [0:0] w1_addr, w1_index, w1_count;

   int n_chk;
   int n_fail;

   bsg_encode_multi_hot_serializer #(.width_p(8), .lo_to_hi_p(1'b1)) u_dut_lh (
      .clk_i(clk), .reset_n_i(rst_n), .v_i(v_in), .i(vec_in), .ready_o(a_ready),
      .v_o(a_v), .addr_o(a_addr), .index_o(a_index), .count_o(a_count),
      .last_o(a_last), .empty_o(a_empty), .yumi_i(yumi));

   bsg_encode_multi_hot_serializer #(.width_p(8), .lo_to_hi_p(1'b0)) u_dut_hl (
      .clk_i(clk), .reset_n_i(rst_n), .v_i(v_in), .i(vec_in), .ready_o(b_ready),
      .v_o(b_v), .addr_o(b_addr), .index_o(b_index), .count_o(b_count),
      .last_o(b_last), .empty_o(b_empty), .yumi_i(yumi));

   bsg_encode_multi_hot_serializer #(.width_p(1), .lo_to_hi_p(1'b1)) u_dut_w1 (
      .clk_i(clk), .reset_n_i(rst_n), .v_i(w1_v_in), .i(w1_vec), .ready_o(w1_ready),
      .v_o(w1_v), .addr_o(w1_addr), .index_o(w1_index), .count_o(w1_count),
      .last_o(w1_last), .empty_o(w1_empty), .yumi_i(w1_yumi));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle();
      chk("lh.ready", 32'(a_ready), 32'd1);
      chk("lh.v",     32'(a_v),     32'd0);
      chk("hl.ready", 32'(b_ready), 32'd1);
      chk("hl.v",     32'(b_v),     32'd0);
   endtask

   // Model: the beat list is simply the set-bit positions, ascending or descending.
   task automatic run_vec(input logic [7:0] vec, input int stall_idx, input int stall_n);
      int q_lh[$];
      int q_hl[$];
      int k;
      int nb;
      int hold;
      for (int b = 0; b < 8; b++) begin
         if (vec[b]) begin
            q_lh.push_back(b);
            q_hl.push_front(b);
         end
      end
      k  = q_lh.size();
      nb = (k == 0) ? 1 : k;
      chk_idle();
      v_in   = 1'b1;
      vec_in = vec;
      tick();
      for (int b = 0; b < nb; b++) begin
         hold = (b == stall_idx) ? stall_n : 0;
         for (int s = 0; s <= hold; s++) begin
            chk("lh.v",     32'(a_v),     32'd1);
            chk("lh.ready", 32'(a_ready), 32'd0);
            chk("lh.addr",  32'(a_addr),  (k == 0) ? 32'd0 : 32'(q_lh[b]));
            chk("hl.addr",  32'(b_addr),  (k == 0) ? 32'd0 : 32'(q_hl[b]));
            chk("lh.index", 32'(a_index), (k == 0) ? 32'd0 : 32'(b));
            chk("hl.index", 32'(b_index), (k == 0) ? 32'd0 : 32'(b));
            chk("lh.count", 32'(a_count), 32'(k));
            chk("hl.count", 32'(b_count), 32'(k));
            chk("lh.last",  32'(a_last),  32'(b == nb - 1));
            chk("hl.last",  32'(b_last),  32'(b == nb - 1));
            chk("lh.empty", 32'(a_empty), 32'(k == 0));
            chk("hl.empty", 32'(b_empty), 32'(k == 0));
            // Input side is noisy while busy; it must be ignored.
            v_in   = 1'($urandom);
            vec_in = 8'($urandom);
            yumi   = (s == hold);
            tick();
         end
      end
      yumi   = 1'b0;
      v_in   = 1'b0;
      chk_idle();
   endtask

   initial begin
      n_chk   = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      v_in    = 1'b0;
      vec_in  = '0;
      yumi    = 1'b0;
      w1_v_in = 1'b0;
      w1_vec  = '0;
      w1_yumi = 1'b0;
      tick();
      tick();

      // Reset state
      chk_idle();
      chk("rst.addr",  32'(a_addr),  32'd0);
      chk("rst.index", 32'(a_index), 32'd0);
      chk("rst.count", 32'(a_count), 32'd0);
      chk("rst.last",  32'(a_last),  32'd0);
      chk("rst.empty", 32'(a_empty), 32'd0);
      chk("rst.last_hl",  32'(b_last),  32'd0);
      chk("w1.rst.ready", 32'(w1_ready), 32'd1);
      chk("w1.rst.v",     32'(w1_v),     32'd0);
      rst_n = 1'b1;
      tick();

      // Directed scans, empty vector, backpressure on beat 4 of all-ones
      run_vec(8'b1010_0100, -1, 0);
      run_vec(8'h00, -1, 0);
      run_vec(8'hFF, 4, 3);
      run_vec(8'h01, -1, 0);
      run_vec(8'h80, 0, 2);

      // Reset in the middle of a vector
      v_in   = 1'b1;
      vec_in = 8'b0001_0110;
      tick();
      v_in   = 1'b0;
      chk("mid.lh.addr",  32'(a_addr),  32'd1);
      chk("mid.hl.addr",  32'(b_addr),  32'd4);
      chk("mid.count",    32'(a_count), 32'd3);
      yumi = 1'b1;
      tick();
      yumi = 1'b0;
      chk("mid.lh.addr2", 32'(a_addr),  32'd2);
      chk("mid.lh.index", 32'(a_index), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk_idle();
      chk("mid.rst.count", 32'(a_count), 32'd0);
      chk("mid.rst.count_hl", 32'(b_count), 32'd0);
      run_vec(8'h80, -1, 0);

      // Randomized vectors with random stalls
      for (int n = 0; n < 40; n++) begin
         run_vec(8'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end

      // Degenerate width
      w1_v_in = 1'b1;
      w1_vec  = 1'b1;
      tick();
      w1_v_in = 1'b0;
      w1_vec  = 1'b0;
      chk("w1.v",     32'(w1_v),     32'd1);
      chk("w1.ready", 32'(w1_ready), 32'd0);
      chk("w1.addr",  32'(w1_addr),  32'd0);
      chk("w1.index", 32'(w1_index), 32'd0);
      chk("w1.count", 32'(w1_count), 32'd1);
      chk("w1.last",  32'(w1_last),  32'd1);
      chk("w1.empty", 32'(w1_empty), 32'd0);
      w1_yumi = 1'b1;
      tick();
      w1_yumi = 1'b0;
      chk("w1.done.ready", 32'(w1_ready), 32'd1);
      chk("w1.done.v",     32'(w1_v),     32'd0);
      w1_v_in = 1'b1;
      tick();
      w1_v_in = 1'b0;
      chk("w1.e.v",     32'(w1_v),     32'd1);
      chk("w1.e.empty", 32'(w1_empty), 32'd1);
      chk("w1.e.last",  32'(w1_last),  32'd1);
      chk("w1.e.count", 32'(w1_count), 32'd0);
      w1_yumi = 1'b1;
      tick();
      w1_yumi = 1'b0;
      chk("w1.e.ready", 32'(w1_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
